data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer placed in front of `data_mem` in the MIPS datapath. It lets the CPU (port 0) and a debug/DMA loader (port 1) share the single data memory. Each request goes through a req/ack handshake with round-robin fairness and word-alignment checking. The block is the only driver of `data_mem`'s `mem_write`, `alu_result` (address) and `write_data` inputs, and it consumes `read_data`.

## Interface
- `ADDR_W`, default 32: byte-address width on requester and memory sides.
- `DATA_W`, default 32: data word width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request from port 0 (CPU) / port 1 (loader).
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  byte address; must be word aligned.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid while the matching ack is high.
- `err0` / `err1`  out  1  misaligned-access flag; valid while the matching ack is high.
- `mem_write`  out  1  to `data_mem.mem_write`.
- `mem_addr`  out  ADDR_W  to `data_mem.alu_result`.
- `mem_wdata`  out  DATA_W  to `data_mem.write_data`.
- `mem_rdata`  in  DATA_W  from `data_mem.read_data` (combinational read).
- `busy`  out  1  high in ACCESS and ACK states.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port other than `last_grant`.
  - On a grant: latch the winner's `we`, `addr`, `wdata` and port id, update `last_grant`, and go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_write` = latched `we` AND (latched `addr[1:0]` == 0).
  - `data_mem` commits the write at the rising edge that ends ACCESS.
  - At that same edge, capture `mem_rdata` into the granted port's `rdata`. A write or a misaligned access captures 0 instead.
  - Set the granted port's `err` to (latched `addr[1:0]` != 0).
  - Go to ACK.
- **ACK** (exactly 1 cycle)
  - Granted port's `ack` = 1. The other port's `ack`, `rdata` and `err` stay 0.
  - Requests are not sampled in ACK.
  - Go to IDLE.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `ack` is seen.
  - A `req` still high in the cycle after `ack` counts as a new request.
- `last_grant` resets to 1, so port 0 wins the first tie. Continuous contention therefore alternates 0, 1, 0, 1…
- `rdata`, `err` and `ack` are registered. They clear to 0 at the edge that leaves ACK.
- A misaligned write never reaches memory (`mem_write` stays 0). A misaligned read returns 0 with `err` = 1.
- Address bits are not otherwise decoded; `data_mem` owns range handling.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1.
  - All latched registers = 0.
  - `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `ack*` = 0, `rdata*` = 0, `err*` = 0, `busy` = 0.
- Latency: request sampled at edge E0 (IDLE) → ACCESS during E0..E1 → `ack` high during E1..E2.
- Throughput: one transaction per 3 cycles. The arbiter is idle for at least 1 cycle between transactions.
- Outside ACCESS, `mem_write` is 0. `mem_addr` and `mem_wdata` hold the last latched values.
- A request that appears in ACCESS or ACK waits and is sampled in the next IDLE cycle.
- Reset asserted during ACCESS:
  - The write already presented in that cycle still commits at the same edge, because `data_mem` is not reset.
  - No `ack` is issued; the next state is IDLE with reset values.
- Reset asserted during ACK: `ack` drops at that edge.
- Reset held for several cycles: no grants, `mem_write` = 0.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `req0` = `req1` = 1 → every output is 0, no `ack`, and `mem_write` never rises.
- **Port 0 write then read:**
  - `req0`, `we0` = 1, `addr0` = 0x4, `wdata0` = 0xDEADBEEF → `mem_write` = 1 for exactly one cycle, `ack0` 2 cycles after sampling, `err0` = 0.
  - Then read 0x4 → `rdata0` = 0xDEADBEEF while `ack0` is high.
- **Contention:**
  - Both ports request from reset; port 0 writes 0x8 = 0xCAFEBABE, port 1 reads 0x8 → port 0 is acked first.
  - Port 1's `ack1` comes 3 cycles later with `rdata1` = 0xCAFEBABE.
  - With both `req` lines kept high, grants alternate 0, 1, 0, 1.
- **Misaligned write:** `req1`, `we1` = 1, `addr1` = 0x6, `wdata1` = 0x12345678 → `mem_write` stays 0, `ack1` with `err1` = 1. A later read of 0x4 still returns 0xDEADBEEF.
- **Unwritten address:** read 0xC after reset → `rdata0` = 0x00000000, `err0` = 0.
- **Reset mid-transaction:** assert `reset` during the ACCESS cycle of a write 0x10 = 0xA5A5A5A5 → no `ack`, FSM returns to IDLE. A read of 0x10 after reset returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single MIPS data memory between the CPU (port 0)
// and a debug/DMA loader (port 1). Each request is served as a three-phase
// IDLE -> ACCESS -> ACK sequence with round-robin tie breaking and a
// word-alignment check that blocks misaligned writes and zeroes misaligned reads.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,

  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;

  logic              anyReq;
  logic              grant1;
  logic              misaligned;
  logic              addrAligned;
  logic [DATA_W-1:0] captureData;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign anyReq = req0 | req1;
  assign grant1 = req1 & (~req0 | ~lastGrant_q);

  // Alignment of the latched address decides whether memory is touched and what is returned.
  assign addrAligned = (addr_q[1:0] == 2'b00);
  assign misaligned  = ~addrAligned;
  assign captureData = (we_q | misaligned) ? '0 : mem_rdata;

  // Next-state logic: arbitration in IDLE, result capture in ACCESS, cleanup in ACK.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          port_d      = grant1;
          lastGrant_d = grant1;
          we_d        = grant1 ? we1 : we0;
          addr_d      = grant1 ? addr1 : addr0;
          wdata_d     = grant1 ? wdata1 : wdata0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (port_q) begin
          ack1_d   = 1'b1;
          rdata1_d = captureData;
          err1_d   = misaligned;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = captureData;
          err0_d   = misaligned;
        end
        state_d = ACK;
      end

      ACK: begin
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = '0;
        rdata1_d = '0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset returns to IDLE with port 0 favoured on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
    end
  end

  // The write strobe is decoded from the current state so a write already on the
  // memory bus still commits if reset arrives during ACCESS (data_mem is not reset).
  assign mem_write = (state_q == ACCESS) & we_q & addrAligned;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a small
// behavioural data_mem and a queue of expected completions.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  int vectors     = 0;
  int miscompares = 0;
  int writeCount  = 0;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .err0      (err0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .err1      (err1),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_mem: combinational read, write at the rising edge, never reset.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      writeCount <= writeCount + 1;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic expectTxn(input logic port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sbq.push_back(e);
  endtask

  // Waits (bounded) for an ack, checks latency from the call point, then pops and compares.
  task automatic waitAck(input string tag, input int expLat);
    int   n   = 0;
    bit   got = 0;
    exp_t e;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (ack0 === 1'b1 || ack1 === 1'b1) got = 1;
    end
    checkOutput({tag, "_latency"}, n, expLat);
    if (got) begin
      checkOutput({tag, "_sb_nonempty"}, {31'd0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput({tag, "_ackpair"}, {30'd0, ack0, ack1}, e.port ? 32'd1 : 32'd2);
        checkOutput({tag, "_rdata"}, e.port ? rdata1 : rdata0, e.rdata);
        checkOutput({tag, "_err"}, {31'd0, e.port ? err1 : err0}, {31'd0, e.err});
        checkOutput({tag, "_other"}, e.port ? (rdata0 | {31'd0, err0}) : (rdata1 | {31'd0, err1}), 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
  endtask

  // Drops both requests and moves to the following IDLE cycle, where acks must be gone.
  task automatic releasePorts(input string tag);
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ack_cleared"}, {30'd0, ack0, ack1}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int wc;

    // Reset held two cycles with both ports requesting: nothing may be granted.
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    applyStimulus(1'b0, 1'b1, 32'h8, 32'hCAFEBABE);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("reset_flags", {26'd0, ack0, ack1, err0, err1, mem_write, busy}, 32'd0);
      checkOutput("reset_rdata", rdata0 | rdata1, 32'd0);
      checkOutput("reset_membus", mem_addr | mem_wdata, 32'd0);
    end
    checkOutput("reset_no_write", writeCount, 32'd0);

    // Contention straight out of reset: port 0 writes first, port 1 reads it back.
    reset = 1'b0;
    expectTxn(1'b0, 32'h0, 1'b0);
    expectTxn(1'b1, 32'hCAFEBABE, 1'b0);
    waitAck("cont_p0", 2);
    checkOutput("cont_writes", writeCount, 32'd1);
    req0 = 1'b0; we0 = 1'b0;
    waitAck("cont_p1", 3);
    releasePorts("cont");

    // Port 0 write then read of 0x4.
    wc = writeCount;
    applyStimulus(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
    expectTxn(1'b0, 32'h0, 1'b0);
    waitAck("p0_wr", 2);
    checkOutput("p0_wr_onepulse", writeCount - wc, 32'd1);
    releasePorts("p0_wr");
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0);
    expectTxn(1'b0, 32'hDEADBEEF, 1'b0);
    waitAck("p0_rd", 2);
    releasePorts("p0_rd");

    // Misaligned write on port 1 must not reach memory.
    wc = writeCount;
    applyStimulus(1'b1, 1'b1, 32'h6, 32'h12345678);
    expectTxn(1'b1, 32'h0, 1'b1);
    waitAck("p1_mis_wr", 2);
    checkOutput("p1_mis_nowrite", writeCount - wc, 32'd0);
    releasePorts("p1_mis_wr");

    // Sustained contention alternates 0,1,0,1; 0x4 must still hold DEADBEEF.
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
    expectTxn(1'b0, 32'hDEADBEEF, 1'b0);
    expectTxn(1'b1, 32'hCAFEBABE, 1'b0);
    expectTxn(1'b0, 32'hDEADBEEF, 1'b0);
    expectTxn(1'b1, 32'hCAFEBABE, 1'b0);
    waitAck("alt0", 2);
    waitAck("alt1", 3);
    waitAck("alt2", 3);
    waitAck("alt3", 3);
    releasePorts("alt");

    // Unwritten address reads zero; misaligned read gives zero with err.
    applyStimulus(1'b0, 1'b0, 32'hC, 32'h0);
    expectTxn(1'b0, 32'h0, 1'b0);
    waitAck("p0_unwritten", 2);
    releasePorts("p0_unwritten");
    applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
    expectTxn(1'b0, 32'h0, 1'b1);
    waitAck("p0_mis_rd", 2);
    releasePorts("p0_mis_rd");

    // Reset during ACCESS of a write: write commits, no ack, FSM back to IDLE.
    wc = writeCount;
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
    @(negedge clk);
    checkOutput("rst_access_memwrite", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    checkOutput("rst_access_committed", writeCount - wc, 32'd1);
    checkOutput("rst_access_flags", {27'd0, ack0, ack1, err0, err1, busy}, 32'd0);
    checkOutput("rst_access_addr", mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_flags", {28'd0, ack0, ack1, mem_write, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    expectTxn(1'b0, 32'hA5A5A5A5, 1'b0);
    waitAck("rst_readback", 2);
    releasePorts("rst_readback");

    // Reset during ACK drops the ack at that edge.
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
    expectTxn(1'b1, 32'hDEADBEEF, 1'b0);
    waitAck("rst_ack", 2);
    reset = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("rst_ack_dropped", {29'd0, ack0, ack1, busy}, 32'd0);
    checkOutput("rst_ack_rdata", rdata1, 32'd0);
    reset = 1'b0;

    checkOutput("sb_drained", sbq.size(), 32'd0);
    $display("[TB] directed sequence complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
